// File: rtl/peres_cascade_ctrl_if.sv
// Host/consumer bundle for the reversible-gate sequencer: program load, word load,
// run control and result handshake.
interface peres_cascade_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int IDXW  = $clog2(WIDTH),
    parameter int OPW   = 2 + 3*IDXW,
    parameter int LENW  = $clog2(DEPTH+1)
);
    logic                     prog_we;
    logic [$clog2(DEPTH)-1:0] prog_addr;
    logic [OPW-1:0]           prog_wdata;
    logic [LENW-1:0]          prog_len;
    logic                     dir;
    logic                     load_valid;
    logic                     load_ready;
    logic [WIDTH-1:0]         load_data;
    logic                     start;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     err;

    modport master (
        output prog_we, prog_addr, prog_wdata, prog_len, dir,
        output load_valid, load_data, start, out_ready,
        input  load_ready, busy, out_valid, out_data, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, prog_len, dir,
        input  load_valid, load_data, start, out_ready,
        output load_ready, busy, out_valid, out_data, err
    );
endinterface

// File: rtl/peres_cascade_ctrl.sv
// Runs a stored program of Peres / inverse-Peres / Toffoli ops over a WIDTH-line
// register, one op per clock, forward or as the exact inverse sequence.
module peres_cascade_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int IDXW  = $clog2(WIDTH),
    parameter int OPW   = 2 + 3*IDXW,
    parameter int LENW  = $clog2(DEPTH+1)
) (
    input logic                 clk,
    input logic                 rst_n,
    peres_cascade_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t             fsm;
    logic [WIDTH-1:0] lines;
    logic [AW-1:0]    pc;
    logic [LENW-1:0]  len;
    logic             rev;
    logic             busy_r;
    logic             valid_r;
    logic             ready_r;
    logic             err_r;

    logic [OPW-1:0]   prog [DEPTH];

    logic [OPW-1:0]   op;
    logic [1:0]       typ;
    logic [1:0]       eff_typ;
    logic [IDXW-1:0]  ia;
    logic [IDXW-1:0]  ib;
    logic [IDXW-1:0]  ic;
    logic             legal;
    logic [WIDTH-1:0] lines_next;
    logic [LENW-1:0]  len_start;
    logic [AW-1:0]    last_pc;

    function automatic logic op_legal(input logic [IDXW-1:0] a,
                                      input logic [IDXW-1:0] b,
                                      input logic [IDXW-1:0] c);
        return (a != b) && (a != c) && (b != c) &&
               (int'(a) < WIDTH) && (int'(b) < WIDTH) && (int'(c) < WIDTH);
    endfunction

    // Every read uses the pre-op word; only lines b and c may change.
    function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] s,
                                                  input logic [1:0]       t,
                                                  input logic [IDXW-1:0]  a,
                                                  input logic [IDXW-1:0]  b,
                                                  input logic [IDXW-1:0]  c);
        logic [WIDTH-1:0] n;
        logic sa, sb, sc;
        n  = s;
        sa = s[a];
        sb = s[b];
        sc = s[c];
        case (t)
            2'b01: begin
                n[b] = sb ^ sa;
                n[c] = sc ^ (sa & sb);
            end
            2'b10: begin
                n[c] = sc ^ (sa & ~sb);
                n[b] = sb ^ sa;
            end
            2'b11:   n[c] = sc ^ (sa & sb);
            default: n = s;
        endcase
        return n;
    endfunction

    // Program memory is writable only while idle and is never reset.
    always_ff @(posedge clk) begin
        if (fsm == IDLE && bus.prog_we) begin
            prog[bus.prog_addr] <= bus.prog_wdata;
        end
    end

    always_comb begin
        op      = prog[pc];
        typ     = op[OPW-1:OPW-2];
        ia      = op[3*IDXW-1:2*IDXW];
        ib      = op[2*IDXW-1:IDXW];
        ic      = op[IDXW-1:0];
        legal   = op_legal(ia, ib, ic);
        // Reverse runs swap Peres and its inverse; Toffoli is self-inverse.
        eff_typ = (rev && (typ == 2'b01 || typ == 2'b10)) ? ~typ : typ;
        lines_next = legal ? apply_op(lines, eff_typ, ia, ib, ic) : lines;
        len_start  = (bus.prog_len > LENW'(DEPTH)) ? LENW'(DEPTH) : bus.prog_len;
        last_pc    = rev ? '0 : AW'(len - LENW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            lines   <= '0;
            pc      <= '0;
            len     <= '0;
            rev     <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.load_valid && ready_r) begin
                        lines <= bus.load_data;
                    end
                    if (bus.start) begin
                        len     <= len_start;
                        rev     <= bus.dir;
                        err_r   <= 1'b0;
                        ready_r <= 1'b0;
                        if (len_start == '0) begin
                            fsm     <= DONE;
                            valid_r <= 1'b1;
                        end else begin
                            fsm    <= RUN;
                            busy_r <= 1'b1;
                            pc     <= bus.dir ? AW'(len_start - LENW'(1)) : '0;
                        end
                    end
                end
                RUN: begin
                    lines <= lines_next;
                    if (!legal) begin
                        err_r <= 1'b1;
                    end
                    if (pc == last_pc) begin
                        fsm     <= DONE;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b1;
                    end else begin
                        pc <= rev ? pc - AW'(1) : pc + AW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm     <= IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.load_ready = ready_r;
    assign bus.busy       = busy_r;
    assign bus.out_valid  = valid_r;
    assign bus.out_data   = lines;
    assign bus.err        = err_r;
endmodule

// File: tb/tb_peres_cascade_ctrl.sv
// Scoreboarded bench for peres_cascade_ctrl: directed cases plus randomized programs
// checked against a line-array reference model.
module tb_peres_cascade_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int IDXW  = 3;
    localparam int OPW   = 11;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             e;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen = 1'b0;
    exp_t sb[$];
    logic [OPW-1:0] pmem [DEPTH];

    peres_cascade_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    peres_cascade_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [OPW-1:0] mk(input int t, input int a, input int b, input int c);
        logic [1:0] tt = 2'(t);
        logic [IDXW-1:0] aa = IDXW'(a);
        logic [IDXW-1:0] bb = IDXW'(b);
        logic [IDXW-1:0] cc = IDXW'(c);
        return {tt, aa, bb, cc};
    endfunction

    // Reference: unpack the word into lines, then walk the op list in program order.
    function automatic logic [WIDTH:0] model_run(input logic [WIDTH-1:0] data, input int len, input bit rev);
        bit s[WIDTH];
        bit e = 1'b0;
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) s[i] = data[i];
        for (int k = 0; k < len; k++) begin
            int idx = rev ? len - 1 - k : k;
            logic [OPW-1:0] o = pmem[idx];
            int t = int'(o[OPW-1:OPW-2]);
            int a = int'(o[8:6]);
            int b = int'(o[5:3]);
            int c = int'(o[2:0]);
            if (a == b || a == c || b == c || a >= WIDTH || b >= WIDTH || c >= WIDTH) begin
                e = 1'b1;
                continue;
            end
            if (rev && t == 1) t = 2;
            else if (rev && t == 2) t = 1;
            if (t == 1) begin
                s[c] = s[c] ^ (s[a] & s[b]);
                s[b] = s[b] ^ s[a];
            end else if (t == 2) begin
                s[c] = s[c] ^ (s[a] & !s[b]);
                s[b] = s[b] ^ s[a];
            end else if (t == 3) begin
                s[c] = s[c] ^ (s[a] & s[b]);
            end
        end
        for (int i = 0; i < WIDTH; i++) r[i] = s[i];
        return {e, r};
    endfunction

    function automatic logic [OPW-1:0] rand_op(input bit allow_bad);
        int a = int'($urandom_range(0, WIDTH-1));
        int b, c;
        do b = int'($urandom_range(0, WIDTH-1)); while (b == a);
        do c = int'($urandom_range(0, WIDTH-1)); while (c == a || c == b);
        if (allow_bad && $urandom_range(0, 5) == 0) c = b;
        return mk(int'($urandom_range(0, 3)), a, b, c);
    endfunction

    // Monitor: checks the first cycle of each DONE episode against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.out_valid && !seen) begin
            exp_t x;
            seen = 1'b1;
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                x = sb.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(x.d));
                chk("err", 32'(bus.err), 32'(x.e));
                chk("latency_cycle", cyc, x.cyc);
            end
        end else if (!bus.out_valid) begin
            seen = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_op(input int addr, input logic [OPW-1:0] o);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = 4'(addr);
        bus.prog_wdata = o;
        tick();
        bus.prog_we = 1'b0;
        pmem[addr] = o;
    endtask

    task automatic run(input logic [WIDTH-1:0] data, input int plen, input bit d,
                       input bit simul, input int hold);
        int len = (plen > DEPTH) ? DEPTH : plen;
        logic [WIDTH:0] m = model_run(data, len, d);
        int n;
        if (!simul) begin
            bus.load_valid = 1'b1;
            bus.load_data  = data;
            tick();
            bus.load_valid = 1'b0;
            bus.load_data  = ~data;
        end
        bus.load_valid = simul;
        bus.load_data  = data;
        bus.prog_len   = 5'(plen);
        bus.dir        = d;
        bus.start      = 1'b1;
        sb.push_back('{m[WIDTH-1:0], m[WIDTH], cyc + 1 + len});
        tick();
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'(len > 0));
        n = 0;
        while (!bus.out_valid && n < DEPTH + 5) begin
            bus.prog_we    = 1'($urandom);
            bus.prog_addr  = 4'($urandom);
            bus.prog_wdata = 11'($urandom);
            tick();
            n++;
        end
        bus.prog_we = 1'b0;
        if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            bus.start      = 1'b1;
            bus.load_valid = 1'b1;
            bus.load_data  = ~data;
            bus.prog_we    = 1'b1;
            bus.prog_addr  = 4'($urandom);
            bus.prog_wdata = 11'($urandom);
            tick();
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_out_data", 32'(bus.out_data), 32'(m[WIDTH-1:0]));
            chk("hold_load_ready", 32'(bus.load_ready), 32'd0);
        end
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        bus.prog_we    = 1'b0;
        bus.out_ready  = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("idle_load_ready", 32'(bus.load_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_out_data_kept", 32'(bus.out_data), 32'(m[WIDTH-1:0]));
    endtask

    initial begin
        logic [WIDTH:0] r;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
        bus.prog_len = '0; bus.dir = 1'b0; bus.load_valid = 1'b0;
        bus.load_data = '0; bus.start = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) write_op(i, '0);

        // Single Peres forward then reverse.
        write_op(0, mk(1, 0, 1, 2));
        run(8'h03, 1, 1'b0, 1'b0, 0);
        run(8'h05, 1, 1'b1, 1'b0, 0);

        // Mixed 4-op program, forward then fed back in reverse.
        write_op(0, mk(1, 0, 1, 2));
        write_op(1, mk(3, 2, 4, 7));
        write_op(2, mk(2, 5, 6, 1));
        write_op(3, mk(1, 7, 3, 0));
        r = model_run(8'hA7, 4, 1'b0);
        run(8'hA7, 4, 1'b0, 1'b0, 0);
        run(r[WIDTH-1:0], 4, 1'b1, 1'b0, 0);

        // Illegal op, then err cleared by the next start (len = 0).
        write_op(0, mk(3, 3, 3, 5));
        run(8'hFF, 1, 1'b0, 1'b0, 0);
        run(8'h3C, 0, 1'b0, 1'b0, 0);

        // Backpressure with gating.
        write_op(0, mk(1, 0, 1, 2));
        run(8'h5B, 4, 1'b0, 1'b0, 5);

        // Simultaneous load and start.
        run(8'h03, 1, 1'b0, 1'b1, 0);

        // Length clamp.
        for (int i = 0; i < DEPTH; i++) write_op(i, rand_op(1'b0));
        run(8'($urandom), DEPTH + 3, 1'b0, 1'b0, 0);
        run(8'($urandom), DEPTH + 3, 1'b1, 1'b0, 1);

        // Reset in the middle of a 4-op run.
        bus.load_valid = 1'b1; bus.load_data = 8'h5A;
        tick();
        bus.load_valid = 1'b0; bus.prog_len = 5'd4; bus.dir = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_data", 32'(bus.out_data), 32'd0);
        chk("midrst_load_ready", 32'(bus.load_ready), 32'd1);
        rst_n = 1'b1;
        run(8'h5A, 4, 1'b0, 1'b0, 0);

        // Randomized programs, directions, lengths and backpressure.
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < 4; w++) write_op(int'($urandom_range(0, DEPTH-1)), rand_op(1'b1));
            run(8'($urandom), int'($urandom_range(0, DEPTH + 2)), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 3)));
        end

        tick(); tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/peres_cascade_ctrl.md
Name: peres_cascade_ctrl

Overview:
- Sequencer that runs a stored program of reversible gate ops (Peres, inverse Peres, Toffoli) on a WIDTH-line state register, one op per clock, through a single shared gate datapath.
- Runs the program forward, or in reverse with each gate replaced by its inverse, so a reverse run recovers the original input.
- Sits between a host loader and downstream consumers of the transformed word. Uses valid/ready on input and output.

Parameters:
- WIDTH, 8, number of reversible lines (bits) in the state register; must be ≥3.
- DEPTH, 16, program memory depth in ops.
- IDXW, $clog2(WIDTH), line-index width.
- OPW, 2+3*IDXW, op word width.
- LENW, $clog2(DEPTH+1), program length width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- prog_we  in  1  program memory write strobe; honoured only in IDLE
- prog_addr  in  $clog2(DEPTH)  program write address
- prog_wdata  in  OPW  op word: [OPW-1:OPW-2] type, then a, b, c indices, with c in the LSBs
- prog_len  in  LENW  op count, sampled at start
- dir  in  1  0 = forward, 1 = reverse; sampled at start
- load_valid  in  1  input word valid
- load_ready  out  1  high in IDLE only
- load_data  in  WIDTH  input word
- start  in  1  begin run; honoured only in IDLE
- busy  out  1  high in RUN
- out_valid  out  1  result valid; high in DONE
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  state register contents
- err  out  1  sticky illegal-op flag; cleared by start or reset

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE; state register = 0; pc = 0; busy = 0; out_valid = 0; err = 0.
  - Program memory contents are not reset.
  - Reset takes effect from any state, including mid-RUN. Any partial result is discarded.
- Op types:
  - 00 NOP.
  - 01 PERES: s[b] ^= s[a]; s[c] ^= s[a] & s[b]_old.
  - 10 PERES_INV: s[c] ^= s[a] & ~s[b]_old; s[b] ^= s[a].
  - 11 TOFFOLI: s[c] ^= s[a] & s[b].
  - All reads of an op use pre-op values. Lines other than a, b, c are unchanged.
- Illegal op: any two of a, b, c equal, or any index ≥ WIDTH. The op executes as a NOP and sets err.
- Reverse mode:
  - pc starts at len-1 and decrements.
  - PERES executes as PERES_INV and vice versa.
  - TOFFOLI and NOP are unchanged.
- FSM states:
  - IDLE:
    - load_valid && load_ready captures load_data into the state register.
    - start latches len = min(prog_len, DEPTH) and dir, and clears err.
    - If len = 0, go to DONE; otherwise go to RUN with pc = dir ? len-1 : 0.
    - A load and start in the same cycle are both accepted. The run operates on the newly loaded word.
  - RUN:
    - One op is applied per edge. After the op at the final pc (len-1 forward, 0 reverse), go to DONE.
    - start, load_valid and prog_we are ignored.
  - DONE:
    - out_valid = 1; out_data holds stable.
    - out_valid && out_ready returns to IDLE. out_data keeps its value afterwards.
- Latency: start sampled at edge k gives out_valid high after edge k+len. The len = 0 case gives out_valid after edge k.
- Throughput: one op per cycle. No bubbles between ops.
- prog_we in RUN or DONE is dropped. It never corrupts an in-flight run.

Test Plan:
- Forward Peres: prog[0] = PERES (a=0, b=1, c=2), len=1, load 0x03, start, dir=0 → busy for 1 cycle, out_valid one edge after start, out_data = 0x05, err = 0.
- Reverse run: same program, load 0x05, dir=1 → out_data = 0x03. Then a 4-op mixed program run forward on 0xA7 and fed back with dir=1 returns 0xA7; forward out_valid appears exactly 4 edges after start.
- Illegal op: prog[0] = TOFFOLI (a=3, b=3, c=5), len=1, load 0xFF → out_data = 0xFF, err = 1; the next start clears err.
- Backpressure and gating: hold out_ready = 0 for 5 cycles in DONE → out_valid stays 1, out_data is stable, load_ready = 0, start is ignored; out_ready = 1 then returns to IDLE.
- Boundaries: len=0 with load 0x3C → out_valid after 1 edge, out_data = 0x3C. prog_len = DEPTH+3 clamps to DEPTH. Simultaneous load_valid + start with load 0x03 → result computed from 0x03.
- Reset mid-RUN: rst_n low during op 2 of 4 → next cycle state IDLE, out_data = 0, busy = 0, out_valid = 0; program memory retained, so a rerun gives the correct result.
